// File: rtl/supersonic_seq.sv
// supersonic_seq: trigger/timeout/holdoff sequencer for the ultrasonic ranging stage, one result per shot.
// Define SUPERSONIC_SEQ_HOLD_LAST_EN to report the last good distance on errored shots instead of all-ones.
module supersonic_seq #(
  parameter int DIS_W       = 17,
  parameter int TRIG_CYC    = 600,
  parameter int HOLDOFF_CYC = 2500000,
  parameter int ECHO_TO_CYC = 100000,
  parameter int MEAS_TO_CYC = 1500000,
  parameter int CNT_W       = 22
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             trigger,
  input  logic             trig_suc,
  input  logic             meas_valid,
  input  logic [DIS_W-1:0] meas_dist,
  output logic             result_valid,
  output logic [DIS_W-1:0] result_dist,
  output logic [1:0]       result_err,
  output logic             busy
);
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] TRIG      = 3'd1;
  localparam logic [2:0] WAIT_ECHO = 3'd2;
  localparam logic [2:0] MEASURE   = 3'd3;
  localparam logic [2:0] HOLDOFF   = 3'd4;
  logic [2:0]       r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_trig, r_valid;
  logic [DIS_W-1:0] r_dist, w_fill;
  logic [1:0]       r_err, w_err;
  logic             w_trig_done, w_echo_to, w_meas_to, w_hold_done, w_res;
  assign w_trig_done = r_cnt == CNT_W'(TRIG_CYC - 1);
  assign w_echo_to   = r_cnt == CNT_W'(ECHO_TO_CYC - 1);
  assign w_meas_to   = r_cnt == CNT_W'(MEAS_TO_CYC - 1);
  assign w_hold_done = r_cnt == CNT_W'(HOLDOFF_CYC - 1);
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      w_next = en ? TRIG : IDLE;
      TRIG:      w_next = w_trig_done ? WAIT_ECHO : TRIG;
      WAIT_ECHO: w_next = trig_suc ? MEASURE : w_echo_to ? HOLDOFF : WAIT_ECHO;
      MEASURE:   w_next = (meas_valid || w_meas_to) ? HOLDOFF : MEASURE;
      HOLDOFF:   w_next = !w_hold_done ? HOLDOFF : en ? TRIG : IDLE;
      default:   w_next = HOLDOFF;
    endcase
  end
  // an echo or measurement arriving on the timeout cycle beats the timeout
  assign w_res = (r_state == WAIT_ECHO && !trig_suc && w_echo_to) ||
                 (r_state == MEASURE && (meas_valid || w_meas_to));
  assign w_err = r_state == WAIT_ECHO ? 2'b01 : meas_valid ? 2'b00 : 2'b10;
`ifdef SUPERSONIC_SEQ_HOLD_LAST_EN
  logic [DIS_W-1:0] r_last;
  always_ff @(posedge clk) begin
    if (rst) r_last <= '0;
    else if (w_res && w_err == 2'b00) r_last <= meas_dist;
  end
  assign w_fill = r_last;
`else
  assign w_fill = '1;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= HOLDOFF;
      r_cnt   <= '0;
      r_trig  <= 1'b0;
      r_valid <= 1'b0;
      r_dist  <= '0;
      r_err   <= 2'b00;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next != r_state || r_state == IDLE) ? '0 : r_cnt + CNT_W'(1);
      r_trig  <= w_next == TRIG;
      r_valid <= w_res;
      if (w_res) begin
        r_err  <= w_err;
        r_dist <= w_err == 2'b00 ? meas_dist : w_fill;
      end
    end
  end
  assign trigger      = r_trig;
  assign result_valid = r_valid;
  assign result_dist  = r_dist;
  assign result_err   = r_err;
  assign busy         = r_state != IDLE;
endmodule

// File: tb/tb_supersonic_seq.sv
// tb_supersonic_seq: randomized shots checked against a timeline model of the sequencer.
module tb_supersonic_seq;
  localparam int DW = 17, TC = 10, HC = 100, EC = 50, MC = 200;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, trig_suc = 1'b0, meas_valid = 1'b0;
  logic [DW-1:0] meas_dist = '0;
  logic trigger, result_valid, busy;
  logic [DW-1:0] result_dist;
  logic [1:0] result_err;
  int n_cmp = 0, n_bad = 0;
  logic [DW-1:0] last_good = '0;

  supersonic_seq #(.DIS_W(DW), .TRIG_CYC(TC), .HOLDOFF_CYC(HC), .ECHO_TO_CYC(EC),
                   .MEAS_TO_CYC(MC), .CNT_W(22)) dut (
    .clk(clk), .rst(rst), .en(en), .trigger(trigger), .trig_suc(trig_suc),
    .meas_valid(meas_valid), .meas_dist(meas_dist), .result_valid(result_valid),
    .result_dist(result_dist), .result_err(result_err), .busy(busy));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  // Offsets are counted in negedges from the first negedge that sees trigger low.
  // Echo driven at offset ke counts if ke < EC; measurement driven at ke+1+km counts if km < MC.
  task automatic run_shot(input int ke, input int km, input logic [DW-1:0] d, input int drop_k);
    bit echo, meas, en_end, nk_ok, mk_ok;
    int kr, nk, mk, km_eff;
    logic [1:0] xe;
    logic [DW-1:0] xd;
    logic [2:0] xo;
    echo   = ke < EC;
    meas   = echo && km < MC;
    kr     = !echo ? EC : meas ? ke + km + 2 : ke + 1 + MC;
    xe     = !echo ? 2'b01 : meas ? 2'b00 : 2'b10;
`ifdef SUPERSONIC_SEQ_HOLD_LAST_EN
    xd     = meas ? d : last_good;
`else
    xd     = meas ? d : '1;
`endif
    en_end = drop_k < 0 ? en : 1'b0;
    nk     = (echo ? ke : EC) / 2;
    nk_ok  = nk >= 1;
    km_eff = km < MC ? km : MC;
    mk     = ke + 1 + km_eff / 2;
    mk_ok  = echo && km_eff >= 2;
    for (int t = 0; t < TC; t++) begin
      n_cmp++;
      if ({trigger, busy, result_valid} !== 3'b110) begin
        n_bad++;
        $display("FAIL trig_phase t=%0d {trig,busy,rv} got %b want 110", t, {trigger, busy, result_valid});
      end
      trig_suc   = t == 3;
      meas_valid = t == 3;
      meas_dist  = DW'($urandom);
      @(negedge clk);
    end
    for (int k = 0; k <= kr + HC; k++) begin
      xo = k == kr + HC ? {en_end, en_end, 1'b0} : {1'b0, 1'b1, k == kr};
      n_cmp++;
      if ({trigger, busy, result_valid} !== xo) begin
        n_bad++;
        $display("FAIL shot_timeline ke=%0d km=%0d k=%0d {trig,busy,rv} got %b want %b", ke, km, k,
                 {trigger, busy, result_valid}, xo);
      end
      if (k == kr) begin
        n_cmp++;
        if (result_err !== xe || result_dist !== xd) begin
          n_bad++;
          $display("FAIL shot_result ke=%0d km=%0d err/dist got %b/%0d want %b/%0d", ke, km,
                   result_err, result_dist, xe, xd);
        end
        if (meas) last_good = d;
      end
      trig_suc   = k == ke || (mk_ok && k == mk);
      meas_valid = k == ke + 1 + km || (nk_ok && k == nk);
      meas_dist  = k == ke + 1 + km ? d : DW'($urandom);
      if (k == drop_k) en = 1'b0;
      if (k < kr + HC) @(negedge clk);
    end
    trig_suc   = 1'b0;
    meas_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    en  = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({trigger, result_valid, busy} !== 3'b001) begin
      n_bad++;
      $display("FAIL reset_ctrl {trig,rv,busy} got %b want 001", {trigger, result_valid, busy});
    end
    n_cmp++;
    if (result_dist !== '0 || result_err !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_result dist/err got %0d/%b want 0/00", result_dist, result_err);
    end
    last_good = '0;
  endtask

  task automatic test_first_trigger;
    int n;
    bit rv_seen;
    n = 0;
    rv_seen = 1'b0;
    rst = 1'b0;
    en  = 1'b1;
    while (trigger !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
      rv_seen |= result_valid === 1'b1;
    end
    n_cmp++;
    if (n !== HC || rv_seen) begin
      n_bad++;
      $display("FAIL first_rise cycles got %0d (rv_seen=%0b) want %0d (0)", n, rv_seen, HC);
    end
  endtask

  task automatic test_good_shot;
    run_shot(20, 79, 17'd1234, -1);
  endtask

  task automatic test_no_echo;
    run_shot(EC, 0, 17'd99, -1);
  endtask

  task automatic test_meas_timeout;
    run_shot(5, MC, 17'd321, -1);
    run_shot(EC - 1, MC - 1, 17'd555, -1);
    run_shot(0, 0, 17'd1, -1);
  endtask

  task automatic test_en_drop;
    run_shot(10, 30, 17'd777, 20);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({trigger, busy, result_valid} !== 3'b000) begin
        n_bad++;
        $display("FAIL idle_hold i=%0d {trig,busy,rv} got %b want 000", i, {trigger, busy, result_valid});
      end
    end
    en = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({trigger, busy} !== 2'b11) begin
      n_bad++;
      $display("FAIL idle_restart {trig,busy} got %b want 11", {trigger, busy});
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 8; i++)
      run_shot(int'($urandom_range(0, 55)), int'($urandom_range(0, 205)), DW'($urandom), -1);
  endtask

  task automatic test_reset_mid;
    int n;
    bit rv_seen;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    meas_valid = 1'b1;
    @(negedge clk);
    meas_valid = 1'b0;
    n_cmp++;
    if ({trigger, busy, result_valid} !== 3'b010) begin
      n_bad++;
      $display("FAIL mid_reset {trig,busy,rv} got %b want 010", {trigger, busy, result_valid});
    end
    n_cmp++;
    if (result_dist !== '0 || result_err !== 2'b00) begin
      n_bad++;
      $display("FAIL mid_reset_result dist/err got %0d/%b want 0/00", result_dist, result_err);
    end
    last_good = '0;
    rst = 1'b0;
    n = 0;
    rv_seen = 1'b0;
    while (trigger !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
      rv_seen |= result_valid === 1'b1;
    end
    n_cmp++;
    if (n !== HC || rv_seen) begin
      n_bad++;
      $display("FAIL mid_reset_holdoff cycles got %0d (rv_seen=%0b) want %0d (0)", n, rv_seen, HC);
    end
    run_shot(60, 0, 17'd5, -1);
  endtask

  initial begin
    test_reset;
    test_first_trigger;
    test_good_shot;
    test_no_echo;
    test_meas_timeout;
    test_en_drop;
    test_random;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
